// File: rtl/roll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : roll_sequencer
// Description : Sequences one dice roll. A press latches the die type and
//               loads its maximum face; holding the button spins a BCD
//               down-counter every cycle; release starts a decelerating
//               settle on the 32 Hz tick (step k waits k ticks); the result
//               is then shown until a timeout blanks the display.
// Ports       : clk          system clock (32768 Hz)
//               rst_n        asynchronous active-low reset
//               i_tick       one-cycle 32 Hz pulse from the prescaler
//               i_btn[6:0]   debounced buttons D4,D6,D8,D10,D12,D20,D100
//               o_digit10    BCD tens digit of the current value
//               o_digit1     BCD units digit of the current value
//               o_die_sel    index 0..6 of the latched die
//               o_blank      1 = display off
//               o_busy       1 while rolling or settling
//               o_roll_done  one-cycle pulse on entry to the show phase
// Revision    : 1.0 - initial release
// ============================================================================
module roll_sequencer #(
  parameter int SETTLE_STEPS = 6,
  parameter int SHOW_TICKS   = 320
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic [6:0] i_btn,
  output logic [3:0] o_digit10,
  output logic [3:0] o_digit1,
  output logic [2:0] o_die_sel,
  output logic       o_blank,
  output logic       o_busy,
  output logic       o_roll_done
);

  localparam int KW = $clog2(SETTLE_STEPS + 1);
  localparam int SW = $clog2(SHOW_TICKS + 1);
  localparam logic [KW-1:0] c_k_last    = KW'(SETTLE_STEPS);
  localparam logic [SW-1:0] c_show_last = SW'(SHOW_TICKS);
  localparam logic [2:0]    c_die_d100  = 3'd6;

  typedef enum logic [1:0] {
    S_SLEEP   = 2'd0,
    S_ROLLING = 2'd1,
    S_SETTLE  = 2'd2,
    S_SHOW    = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_d10, r_d1, w_d10_nxt, w_d1_nxt;
  logic [2:0]    r_die, w_die_nxt;
  logic [KW-1:0] r_k, w_k_nxt, r_tcnt, w_tcnt_nxt, w_tcnt_inc;
  logic [SW-1:0] r_scnt, w_scnt_nxt, w_scnt_inc;
  logic          r_done, w_done_nxt;
  logic [2:0]    w_lsb;
  logic [7:0]    w_load;
  logic [3:0]    w_step_d10, w_step_d1;
  logic          w_press;

  // Maximum face of each die in BCD; D100 loads 00, which stands for 100.
  function automatic logic [7:0] n_bcd(input logic [2:0] d);
    case (d)
      3'd0:    n_bcd = 8'h04;
      3'd1:    n_bcd = 8'h06;
      3'd2:    n_bcd = 8'h08;
      3'd3:    n_bcd = 8'h10;
      3'd4:    n_bcd = 8'h12;
      3'd5:    n_bcd = 8'h20;
      default: n_bcd = 8'h00;
    endcase
  endfunction

  assign w_press    = |i_btn;
  assign w_tcnt_inc = r_tcnt + 1'b1;
  assign w_scnt_inc = r_scnt + 1'b1;

  // Lowest set button wins when several are pressed together.
  always_comb begin
    w_lsb = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (i_btn[i]) w_lsb = 3'(i);
    end
  end

  assign w_load = n_bcd(w_lsb);

  // One BCD decrement step. Ranged dice wrap 01 -> N; D100 wraps 00 -> 99.
  always_comb begin
    w_step_d10 = r_d10;
    w_step_d1  = r_d1;
    if (r_die == c_die_d100 && r_d10 == 4'd0 && r_d1 == 4'd0) begin
      w_step_d10 = 4'd9;
      w_step_d1  = 4'd9;
    end else if (r_die != c_die_d100 && r_d10 == 4'd0 && r_d1 == 4'd1) begin
      {w_step_d10, w_step_d1} = n_bcd(r_die);
    end else if (r_d1 == 4'd0) begin
      w_step_d1  = 4'd9;
      w_step_d10 = r_d10 - 4'd1;
    end else begin
      w_step_d1  = r_d1 - 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_d10_nxt   = r_d10;
    w_d1_nxt    = r_d1;
    w_die_nxt   = r_die;
    w_k_nxt     = r_k;
    w_tcnt_nxt  = r_tcnt;
    w_scnt_nxt  = r_scnt;
    w_done_nxt  = 1'b0;
    o_blank     = 1'b1;
    o_busy      = 1'b0;
    case (r_state)
      S_SLEEP: begin
        if (w_press) begin
          w_state_nxt           = S_ROLLING;
          w_die_nxt             = w_lsb;
          {w_d10_nxt, w_d1_nxt} = w_load;
        end
      end
      S_ROLLING: begin
        o_busy = 1'b1;
        if (w_press) begin
          w_d10_nxt = w_step_d10;
          w_d1_nxt  = w_step_d1;
        end else begin
          w_state_nxt = S_SETTLE;
          w_k_nxt     = KW'(1);
          w_tcnt_nxt  = '0;
        end
      end
      S_SETTLE: begin
        o_blank = 1'b0;
        o_busy  = 1'b1;
        if (i_tick) begin
          if (w_tcnt_inc == r_k) begin
            w_d10_nxt  = w_step_d10;
            w_d1_nxt   = w_step_d1;
            w_tcnt_nxt = '0;
            if (r_k == c_k_last) begin
              w_state_nxt = S_SHOW;
              w_done_nxt  = 1'b1;
              w_scnt_nxt  = '0;
              w_k_nxt     = '0;
            end else begin
              w_k_nxt = r_k + 1'b1;
            end
          end else begin
            w_tcnt_nxt = w_tcnt_inc;
          end
        end
      end
      S_SHOW: begin
        o_blank = 1'b0;
        // A new press outranks a timeout landing in the same cycle.
        if (w_press) begin
          w_state_nxt           = S_ROLLING;
          w_die_nxt             = w_lsb;
          {w_d10_nxt, w_d1_nxt} = w_load;
        end else if (i_tick) begin
          if (w_scnt_inc == c_show_last) begin
            w_state_nxt = S_SLEEP;
            w_scnt_nxt  = '0;
          end else begin
            w_scnt_nxt = w_scnt_inc;
          end
        end
      end
      default: w_state_nxt = S_SLEEP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SLEEP;
      r_d10   <= 4'd0;
      r_d1    <= 4'd1;
      r_die   <= 3'd0;
      r_k     <= '0;
      r_tcnt  <= '0;
      r_scnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_d10   <= w_d10_nxt;
      r_d1    <= w_d1_nxt;
      r_die   <= w_die_nxt;
      r_k     <= w_k_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_scnt  <= w_scnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_digit10   = r_d10;
  assign o_digit1    = r_d1;
  assign o_die_sel   = r_die;
  assign o_roll_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_roll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_roll_sequencer
// Description : Randomised scoreboard bench for roll_sequencer. Each roll's
//               expected die and final value come from an integer dice model
//               and are queued; a monitor pops them on o_roll_done and also
//               measures settle and show durations in ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roll_sequencer;

  localparam int SETTLE_STEPS = 6;
  localparam int SHOW_TICKS   = 320;
  localparam int SETTLE_TOTAL = SETTLE_STEPS * (SETTLE_STEPS + 1) / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_tick;
  logic [6:0] i_btn;
  logic [3:0] o_digit10, o_digit1;
  logic [2:0] o_die_sel;
  logic       o_blank, o_busy, o_roll_done;

  roll_sequencer #(.SETTLE_STEPS(SETTLE_STEPS), .SHOW_TICKS(SHOW_TICKS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tick     (i_tick),
    .i_btn      (i_btn),
    .o_digit10  (o_digit10),
    .o_digit1   (o_digit1),
    .o_die_sel  (o_die_sel),
    .o_blank    (o_blank),
    .o_busy     (o_busy),
    .o_roll_done(o_roll_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int die;
    int v;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_v = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference dice model: values as plain integers, 100 shown as 0.
  function automatic int n_of(input int d);
    case (d)
      0: return 4;
      1: return 6;
      2: return 8;
      3: return 10;
      4: return 12;
      5: return 20;
      default: return 100;
    endcase
  endfunction

  function automatic int step_of(input int d, input int v);
    if (d == 6) return (v + 99) % 100;
    return (v == 1) ? n_of(d) : v - 1;
  endfunction

  // 32 Hz tick stand-in: one-cycle pulse every 5 clocks.
  initial begin : tick_gen
    i_tick = 1'b0;
    forever begin
      repeat (4) @(posedge clk);
      #1 i_tick = 1'b1;
      @(posedge clk);
      #1 i_tick = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on roll_done, times settle and show phases.
  initial begin : monitor
    int  settle_t, show_t;
    bit  prev_show, prev_done, is_settle, is_show;
    exp_t e;
    settle_t = 0; show_t = 0; prev_show = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        settle_t = 0; show_t = 0; prev_show = 0; prev_done = 0;
        continue;
      end
      is_settle = o_busy && !o_blank;
      is_show   = !o_busy && !o_blank;
      if (prev_done) chk("roll_done_width", o_roll_done, 0);
      if (o_roll_done) begin
        if (q.size() == 0) begin
          chk("unexpected_roll_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("die_sel", o_die_sel, e.die);
          chk("final_value", o_digit10 * 10 + o_digit1, e.v);
          chk("digit_tens", o_digit10, e.v / 10);
          chk("settle_ticks", settle_t, SETTLE_TOTAL);
          last_v = e.v;
        end
        settle_t = 0;
      end
      if (prev_show && o_blank && !o_busy) begin
        chk("show_ticks", show_t, SHOW_TICKS);
        chk("sleep_digits", o_digit10 * 10 + o_digit1, last_v);
        show_t = 0;
      end
      if (o_busy && o_blank) settle_t = 0;
      if (o_busy) show_t = 0;
      if (i_tick && is_settle) settle_t++;
      if (i_tick && is_show) show_t++;
      prev_show = is_show;
      prev_done = o_roll_done;
    end
  end

  task automatic wait_done();
    int n = 0;
    while (n < 600) begin
      @(negedge clk);
      if (o_roll_done) break;
      n++;
    end
    chk("roll_done_seen", int'(n < 600), 1);
  endtask

  task automatic wait_sleep();
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (o_blank && !o_busy) break;
      n++;
    end
    chk("timeout_to_sleep", int'(n < 2000), 1);
  endtask

  // Hold b0 for h cycles (switching to b1 from cycle sw on), then release.
  task automatic do_roll(input logic [6:0] b0, input logic [6:0] b1,
                         input int h, input int sw, input bit poke);
    int d, v;
    exp_t e;
    d = 0;
    for (int i = 6; i >= 0; i--) if (b0[i]) d = i;
    v = n_of(d) % 100;
    for (int s = 0; s < h - 1 + SETTLE_STEPS; s++) v = step_of(d, v);
    e.die = d;
    e.v   = v;
    q.push_back(e);
    @(posedge clk); #1 i_btn = b0;
    @(posedge clk); #1;
    chk("busy_after_press", o_busy, 1);
    chk("blank_rolling", o_blank, 1);
    for (int c = 1; c < h; c++) begin
      i_btn = (c >= sw) ? b1 : b0;
      @(posedge clk); #1;
    end
    i_btn = '0;
    if (poke) begin
      repeat (10) @(posedge clk);
      #1 i_btn = 7'b0001000;
      @(posedge clk);
      #1 i_btn = '0;
    end
    wait_done();
  endtask

  initial begin : stim
    logic [6:0] b0, b1;
    int h;
    rst_n = 1'b0;
    i_btn = '0;
    #12;
    chk("rst_digit10", o_digit10, 0);
    chk("rst_digit1", o_digit1, 1);
    chk("rst_blank", o_blank, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_die_sel", o_die_sel, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("sleep_blank", o_blank, 1);
    chk("sleep_busy", o_busy, 0);

    do_roll(7'b0000001, 7'b0000001, 5, 99, 1'b0);
    do_roll(7'b1000000, 7'b1000000, 3, 99, 1'b0);
    do_roll(7'b0100010, 7'b1000000, 12, 4, 1'b0);
    do_roll(7'b0001000, 7'b0001000, 7, 99, 1'b1);
    wait_sleep();
    chk("sleep_roll_done", o_roll_done, 0);

    // Press after roughly 100 ticks of SHOW restarts the roll.
    do_roll(7'b0010000, 7'b0010000, 4, 99, 1'b0);
    repeat (500) @(posedge clk);
    do_roll(7'b0000100, 7'b0000100, 9, 99, 1'b0);

    for (int r = 0; r < 20; r++) begin
      b0 = 7'($urandom_range(1, 127));
      b1 = 7'($urandom_range(1, 127));
      h  = $urandom_range(1, 30);
      do_roll(b0, b1, h, $urandom_range(1, h + 1), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 200)) @(posedge clk);
    end

    // Asynchronous reset mid-roll aborts immediately.
    @(posedge clk); #1 i_btn = 7'b0000100;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_digit10", o_digit10, 0);
    chk("abort_digit1", o_digit1, 1);
    chk("abort_blank", o_blank, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_die_sel", o_die_sel, 0);
    i_btn = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_sleep_busy", o_busy, 0);
    chk("abort_sleep_blank", o_blank, 1);
    last_v = 1;
    do_roll(7'b0100000, 7'b0100000, 6, 99, 1'b0);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
